// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter.
// Holds the FSM encoding, the output bundle and the rotate/pick function.
package bus_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
  } arb_out_t;

  // First set bit searching last+1, last+2, ... modulo 4.
  // Walk from farthest to nearest so the nearest hit wins.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] last
  );
    logic [1:0] idx;
    logic [1:0] win;
    win = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

  function automatic logic [3:0] onehot4(
    input logic [1:0] i
  );
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick4.sv
// Combinational 4-way round-robin priority encoder.
// Search starts just after the last winner.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  // Rotated priority search plus a "something to pick" flag.
  always_comb begin
    pick = rr_pick(req, last);
    any  = |req;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for one shared bus, 4 requesters.
// Tenure limit, 1-cycle turnaround gap, contention flag.
module bus_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             bus_busy,
  output logic             preempt,
  output logic             contention
);

  import bus_arb_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_t        state;
  arb_state_t        state_nx;
  arb_out_t          r;
  arb_out_t          r_nx;
  logic [1:0]        last;
  logic [1:0]        last_nx;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_nx;
  logic [1:0]        win;
  logic              any;
  logic [3:0]        others;
  logic              maj;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .pick (win),
    .any  (any)
  );

  // Requests from everyone except the current holder.
  always_comb begin
    others = req & ~r.gnt;
  end

  // At least 3 of 4 requests: 4-input majority term.
  always_comb begin
    maj = (req[0] & req[1] & req[2])
        | (req[0] & req[1] & req[3])
        | (req[0] & req[2] & req[3])
        | (req[1] & req[2] & req[3]);
  end

  // Next-state and next-output decision.
  always_comb begin
    state_nx = state;
    r_nx     = r;
    r_nx.pre = 1'b0;
    last_nx  = last;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (any) begin
          r_nx.gnt = onehot4(win);
          r_nx.id  = win;
          last_nx  = win;
          cnt_nx   = HOLD_ONE;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!req[r.id]) begin
          r_nx.gnt = 4'b0000;
          state_nx = GAP;
        end else if (cnt == HOLD_MAX && |others) begin
          r_nx.gnt = 4'b0000;
          r_nx.pre = 1'b1;
          state_nx = GAP;
        end else if (cnt != HOLD_MAX) begin
          cnt_nx = cnt + HOLD_ONE;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        r_nx.gnt = 4'b0000;
        state_nx = IDLE;
      end
    endcase
  end

  // FSM, pointer, tenure counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  // Contention flag, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention <= 1'b0;
    end else begin
      contention <= maj;
    end
  end

  assign gnt      = r.gnt;
  assign gnt_id   = r.id;
  assign preempt  = r.pre;
  assign bus_busy = |r.gnt;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter.
// Vector table plus hand-written tenure/reset sequences.
module tb_bus_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       bus_busy;
  logic       preempt;
  logic       contention;

  int n_chk;
  int n_pass;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
    logic       cont;
  } vec_t;

  vec_t tbl[64];
  int   nv;

  bus_rr_arbiter #(
    .N_REQ    (4),
    .MAX_HOLD (8),
    .HOLD_W   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .bus_busy   (bus_busy),
    .preempt    (preempt),
    .contention (contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(
    input logic [3:0] r,
    input logic [3:0] g,
    input logic [1:0] id,
    input logic       pre,
    input logic       cont
  );
    tbl[nv].req  = r;
    tbl[nv].gnt  = g;
    tbl[nv].id   = id;
    tbl[nv].pre  = pre;
    tbl[nv].cont = cont;
    nv++;
  endfunction

  // Compare {gnt, gnt_id, bus_busy, preempt, contention}.
  task automatic check(
    input string      name,
    input logic [3:0] g,
    input logic [1:0] id,
    input logic       pre,
    input logic       cont
  );
    logic [8:0] act;
    logic [8:0] exp;
    act = {gnt, gnt_id, bus_busy, preempt, contention};
    exp = {g, id, |g, pre, cont};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got gnt/id/busy/pre/cont=%b required %b",
                  name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    nv     = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;

    // single requester grant and release
    add(4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // 0110 with release on 3rd grant cycle: 1,2,1,2
    add(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0);
    add(4'b0100, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0);
    add(4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0);
    add(4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0);
    add(4'b0010, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0110, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0);
    add(4'b0100, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    // lone requester 2 holds past the tenure limit
    for (int i = 0; i < 20; i++)
      add(4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < nv; i++) begin
      step(tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id,
            tbl[i].pre, tbl[i].cont);
    end

    // full contention: 8-cycle tenures, preempt each handoff
    do_reset();
    for (int k = 0; k < 50; k++) begin
      int p;
      int id;
      logic [3:0] g;
      p  = k % 10;
      id = (k / 10) % 4;
      g  = (p < 8) ? (4'b0001 << id) : 4'b0000;
      step(4'b1111);
      check($sformatf("rr1111_c%0d", k), g, 2'(id), p == 8, 1'b1);
    end

    // holder drops exactly when tenure expires: no preempt
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1001);
      check($sformatf("exp_c%0d", k), 4'b0001, 2'd0, 1'b0, 1'b0);
    end
    step(4'b1000);
    check("exp_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1000);
    check("exp_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1000);
    check("exp_next", 4'b1000, 2'd3, 1'b0, 1'b0);

    // async reset in the middle of a grant to requester 1
    do_reset();
    step(4'b1110);
    check("mid_gnt", 4'b0010, 2'd1, 1'b0, 1'b1);
    step(4'b1110);
    check("mid_hold", 4'b0010, 2'd1, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1111;
    @(posedge clk);
    #1;
    check("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", 4'b0001, 2'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
